// File: rtl/rv_mem_arb.sv
// rv_mem_arb: single-port memory arbiter and access sequencer for the
// multicycle RISC-V core. Serialises instruction-fetch and data requests onto
// one synchronous fixed-latency memory and returns read data together with a
// one-cycle acknowledge pulse.
//
// Optional feature macro: MEMARB_RR_EN
//   defined   : round-robin arbitration on a tie (1-bit last-grant pointer)
//   undefined : fixed priority, data over fetch
//
// Ports
//   clk, rst                 clock, asynchronous active-low reset
//   if_req/if_addr           fetch request and address (held until if_ack)
//   if_ack/if_rdata          fetch complete pulse and fetched word
//   d_req/d_we/d_addr/d_wdata data request, store flag, address, store data
//   d_ack/d_rdata            data complete pulse and load data
//   mem_en/mem_we            memory strobe and write enable (one cycle)
//   mem_addr/mem_wdata       memory address and write data (held per access)
//   mem_rdata                memory read data, valid MEM_LAT cycles after mem_en
//   busy                     high whenever an access is in flight
module rv_mem_arb #(
   parameter int unsigned DPWIDTH = 32,
   parameter int unsigned MEM_LAT = 2
) (
   input  logic               clk,
   input  logic               rst,
   input  logic               if_req,
   input  logic [DPWIDTH-1:0] if_addr,
   output logic               if_ack,
   output logic [DPWIDTH-1:0] if_rdata,
   input  logic               d_req,
   input  logic               d_we,
   input  logic [DPWIDTH-1:0] d_addr,
   input  logic [DPWIDTH-1:0] d_wdata,
   output logic               d_ack,
   output logic [DPWIDTH-1:0] d_rdata,
   output logic               mem_en,
   output logic               mem_we,
   output logic [DPWIDTH-1:0] mem_addr,
   output logic [DPWIDTH-1:0] mem_wdata,
   input  logic [DPWIDTH-1:0] mem_rdata,
   output logic               busy
);

   localparam int unsigned      CNT_W    = 4;
   localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LAT - 1);
   localparam logic             OWN_FETCH = 1'b0;
   localparam logic             OWN_DATA  = 1'b1;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_ISSUE = 2'd1,
      S_WAIT  = 2'd2,
      S_RESP  = 2'd3
   } state_t;

   state_t             r_state,  w_state_nxt;
   logic [CNT_W-1:0]   r_cnt,    w_cnt_nxt;
   logic               r_own,    w_own_nxt;
   logic               r_we,     w_we_nxt;
   logic [DPWIDTH-1:0] r_addr,   w_addr_nxt;
   logic [DPWIDTH-1:0] r_wdata,  w_wdata_nxt;
   logic [DPWIDTH-1:0] r_if_rdata, w_if_rdata_nxt;
   logic [DPWIDTH-1:0] r_d_rdata,  w_d_rdata_nxt;
   logic               r_mem_en, w_mem_en_nxt;
   logic               r_mem_we, w_mem_we_nxt;
   logic               r_if_ack, w_if_ack_nxt;
   logic               r_d_ack,  w_d_ack_nxt;
   logic               r_busy,   w_busy_nxt;
   logic               w_grant_d;

`ifdef MEMARB_RR_EN
   // Last granted owner; resets to DATA so the first tie goes to fetch.
   logic               r_ptr,    w_ptr_nxt;

   // Tie goes to whichever requester was not granted last.
   assign w_grant_d = d_req & (~if_req | (r_ptr == OWN_FETCH));
`else
   // Fixed priority: data wins whenever it is requesting.
   assign w_grant_d = d_req;
`endif

   // State register and all registered outputs.
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         r_state    <= S_IDLE;
         r_cnt      <= '0;
         r_own      <= OWN_FETCH;
         r_we       <= 1'b0;
         r_addr     <= '0;
         r_wdata    <= '0;
         r_if_rdata <= '0;
         r_d_rdata  <= '0;
         r_mem_en   <= 1'b0;
         r_mem_we   <= 1'b0;
         r_if_ack   <= 1'b0;
         r_d_ack    <= 1'b0;
         r_busy     <= 1'b0;
`ifdef MEMARB_RR_EN
         r_ptr      <= OWN_DATA;
`endif
      end else begin
         r_state    <= w_state_nxt;
         r_cnt      <= w_cnt_nxt;
         r_own      <= w_own_nxt;
         r_we       <= w_we_nxt;
         r_addr     <= w_addr_nxt;
         r_wdata    <= w_wdata_nxt;
         r_if_rdata <= w_if_rdata_nxt;
         r_d_rdata  <= w_d_rdata_nxt;
         r_mem_en   <= w_mem_en_nxt;
         r_mem_we   <= w_mem_we_nxt;
         r_if_ack   <= w_if_ack_nxt;
         r_d_ack    <= w_d_ack_nxt;
         r_busy     <= w_busy_nxt;
`ifdef MEMARB_RR_EN
         r_ptr      <= w_ptr_nxt;
`endif
      end
   end

   // Next-state and next-output logic. Strobes and acks are computed one
   // cycle early so they appear registered in ISSUE and RESP respectively.
   always_comb begin
      w_state_nxt    = r_state;
      w_cnt_nxt      = r_cnt;
      w_own_nxt      = r_own;
      w_we_nxt       = r_we;
      w_addr_nxt     = r_addr;
      w_wdata_nxt    = r_wdata;
      w_if_rdata_nxt = r_if_rdata;
      w_d_rdata_nxt  = r_d_rdata;
      w_mem_en_nxt   = 1'b0;
      w_mem_we_nxt   = 1'b0;
      w_if_ack_nxt   = 1'b0;
      w_d_ack_nxt    = 1'b0;
`ifdef MEMARB_RR_EN
      w_ptr_nxt      = r_ptr;
`endif

      case (r_state)
         S_IDLE: begin
            if (if_req | d_req) begin
               w_own_nxt    = w_grant_d ? OWN_DATA : OWN_FETCH;
               w_we_nxt     = w_grant_d & d_we;
               w_addr_nxt   = w_grant_d ? d_addr : if_addr;
               // Fetches never write; keep the last store data on the bus.
               w_wdata_nxt  = w_grant_d ? d_wdata : r_wdata;
               w_mem_en_nxt = 1'b1;
               w_mem_we_nxt = w_grant_d & d_we;
               w_state_nxt  = S_ISSUE;
`ifdef MEMARB_RR_EN
               w_ptr_nxt    = w_grant_d ? OWN_DATA : OWN_FETCH;
`endif
            end
         end
         S_ISSUE: begin
            w_cnt_nxt   = CNT_LOAD;
            w_state_nxt = S_WAIT;
         end
         S_WAIT: begin
            if (r_cnt == '0) begin
               if (!r_we) begin
                  if (r_own == OWN_DATA) w_d_rdata_nxt  = mem_rdata;
                  else                   w_if_rdata_nxt = mem_rdata;
               end
               w_if_ack_nxt = (r_own == OWN_FETCH);
               w_d_ack_nxt  = (r_own == OWN_DATA);
               w_state_nxt  = S_RESP;
            end else begin
               w_cnt_nxt = r_cnt - CNT_W'(1);
            end
         end
         S_RESP: begin
            w_state_nxt = S_IDLE;
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase

      w_busy_nxt = (w_state_nxt != S_IDLE);
   end

   assign if_ack    = r_if_ack;
   assign if_rdata  = r_if_rdata;
   assign d_ack     = r_d_ack;
   assign d_rdata   = r_d_rdata;
   assign mem_en    = r_mem_en;
   assign mem_we    = r_mem_we;
   assign mem_addr  = r_addr;
   assign mem_wdata = r_wdata;
   assign busy      = r_busy;

endmodule

// File: tb/tb_rv_mem_arb.sv
// tb_rv_mem_arb: self-checking bench for rv_mem_arb.
// u_dut  (MEM_LAT=2) runs directed and random fetch/data traffic against a
//        transaction-level reference (grant cycle arithmetic + word array).
// u_dut1 (MEM_LAT=1) checks the shortest legal latency with a directed load.
`timescale 1ns/1ps
module tb_rv_mem_arb;

   localparam int LAT = 2;

`ifdef MEMARB_RR_EN
   // Ties below occur after a data grant (or after reset): fetch wins.
   localparam int TIE_IF_LAT = 4;
   localparam int TIE_D_LAT  = 9;
`else
   localparam int TIE_IF_LAT = 9;
   localparam int TIE_D_LAT  = 4;
`endif

   logic clk;
   logic rst;
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- main DUT (MEM_LAT=2) ----------------
   logic        if_req, if_ack, d_req, d_we, d_ack, mem_en, mem_we, busy;
   logic [31:0] if_addr, if_rdata, d_addr, d_wdata, d_rdata;
   logic [31:0] mem_addr, mem_wdata, mem_rdata;

   rv_mem_arb #(.DPWIDTH(32), .MEM_LAT(LAT)) u_dut (
      .clk(clk), .rst(rst),
      .if_req(if_req), .if_addr(if_addr), .if_ack(if_ack), .if_rdata(if_rdata),
      .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
      .d_ack(d_ack), .d_rdata(d_rdata),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr),
      .mem_wdata(mem_wdata), .mem_rdata(mem_rdata), .busy(busy)
   );

   // ---------------- second DUT (MEM_LAT=1) ----------------
   logic        if_req1, if_ack1, d_req1, d_we1, d_ack1, mem_en1, mem_we1, busy1;
   logic [31:0] if_addr1, if_rdata1, d_addr1, d_wdata1, d_rdata1;
   logic [31:0] mem_addr1, mem_wdata1, mem_rdata1;

   rv_mem_arb #(.DPWIDTH(32), .MEM_LAT(1)) u_dut1 (
      .clk(clk), .rst(rst),
      .if_req(if_req1), .if_addr(if_addr1), .if_ack(if_ack1), .if_rdata(if_rdata1),
      .d_req(d_req1), .d_we(d_we1), .d_addr(d_addr1), .d_wdata(d_wdata1),
      .d_ack(d_ack1), .d_rdata(d_rdata1),
      .mem_en(mem_en1), .mem_we(mem_we1), .mem_addr(mem_addr1),
      .mem_wdata(mem_wdata1), .mem_rdata(mem_rdata1), .busy(busy1)
   );

   function automatic logic [31:0] init_word(input int i);
      if (i == 4) return 32'h0050_0093;
      return {8'(i), 8'h3C, 8'(~i), 8'hA5};
   endfunction

   // Memory model for u_dut: write on strobe, read data after LAT cycles.
   logic [31:0] tb_mem [256];
   logic [31:0] rd_pipe [LAT];
   always @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < 256; i++) tb_mem[i] <= init_word(i);
      end else if (mem_en && mem_we) begin
         tb_mem[mem_addr[9:2]] <= mem_wdata;
      end
      rd_pipe[0] <= mem_en ? tb_mem[mem_addr[9:2]] : 32'hBAD0_BAD0;
      for (int k = 1; k < LAT; k++) rd_pipe[k] <= rd_pipe[k-1];
   end
   assign mem_rdata = rd_pipe[LAT-1];

   // ---------------- scoreboard / reference ----------------
   int unsigned n_vec = 0;
   int unsigned n_err = 0;
   int          c;
   int          free_c;
   bit          g_valid, g_d, g_we;
   int          g_c;
   logic [31:0] g_addr, g_wdata, g_rd;
   bit          last_d;
   logic [31:0] ref_mem [256];
   logic [31:0] e_mem_addr, e_if_rdata, e_d_rdata;
   bit          drop_if, drop_d;
   int unsigned raise_pct;
   bit          want_if, want_d, want_d_we;
   logic [31:0] want_if_addr, want_d_addr, want_d_wdata;
   int          raise_if_c, raise_d_c, if_ack_c, d_ack_c;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s cyc=%0d got=%h exp=%h", tag, c, got, exp);
      end
   endtask

   task automatic model_reset();
      for (int i = 0; i < 256; i++) ref_mem[i] = init_word(i);
      g_valid = 1'b0; last_d = 1'b1; free_c = 0; c = 0;
      e_mem_addr = '0; e_if_rdata = '0; e_d_rdata = '0;
      drop_if = 1'b0; drop_d = 1'b0; want_if = 1'b0; want_d = 1'b0;
   endtask

   // One clock cycle: check cycle c outputs, then drive cycle c inputs and
   // predict any grant the arbiter makes at the end of cycle c.
   task automatic tick();
      logic e_en, e_busy, e_if_ack, e_d_ack;
      bit   gd;
      @(negedge clk);
      c++;
      e_en     = g_valid && (c == g_c + 1);
      e_busy   = g_valid && (c > g_c) && (c <= g_c + 2 + LAT);
      e_if_ack = g_valid && !g_d && (c == g_c + 2 + LAT);
      e_d_ack  = g_valid &&  g_d && (c == g_c + 2 + LAT);
      if (e_en) e_mem_addr = g_addr;
      if (e_if_ack) e_if_rdata = g_rd;
      if (e_d_ack && !g_we) e_d_rdata = g_rd;

      check("mem_en",   32'(mem_en), 32'(e_en));
      check("busy",     32'(busy),   32'(e_busy));
      check("if_ack",   32'(if_ack), 32'(e_if_ack));
      check("d_ack",    32'(d_ack),  32'(e_d_ack));
      check("mem_addr", mem_addr,    e_mem_addr);
      check("if_rdata", if_rdata,    e_if_rdata);
      check("d_rdata",  d_rdata,     e_d_rdata);
      if (e_en) begin
         check("mem_we", 32'(mem_we), 32'(g_we));
         if (g_we) check("mem_wdata", mem_wdata, g_wdata);
      end
      if (if_ack) if_ack_c = c;
      if (d_ack)  d_ack_c  = c;

      // Requesters hold through the ack cycle and release the cycle after.
      if (drop_if) if_req = 1'b0;
      if (drop_d)  d_req  = 1'b0;
      drop_if = e_if_ack;
      drop_d  = e_d_ack;

      if (!if_req) begin
         if (want_if) begin
            if_req = 1'b1; if_addr = want_if_addr; want_if = 1'b0; raise_if_c = c;
         end else if ($urandom_range(0, 99) < raise_pct) begin
            if_req = 1'b1; if_addr = $urandom & 32'hFFFF_FFFC;
         end else begin
            if_addr = $urandom;
         end
      end
      if (!d_req) begin
         if (want_d) begin
            d_req = 1'b1; d_we = want_d_we; d_addr = want_d_addr;
            d_wdata = want_d_wdata; want_d = 1'b0; raise_d_c = c;
         end else if ($urandom_range(0, 99) < raise_pct) begin
            d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
            d_addr = $urandom & 32'hFFFF_FFFC; d_wdata = $urandom;
         end else begin
            d_we = 1'($urandom_range(0, 1)); d_addr = $urandom; d_wdata = $urandom;
         end
      end

      // Reference arbitration: lone request wins; tie by mode.
      if (c >= free_c && (if_req || d_req)) begin
         if (if_req && d_req) begin
`ifdef MEMARB_RR_EN
            gd = !last_d;
`else
            gd = 1'b1;
`endif
         end else begin
            gd = d_req;
         end
         g_valid = 1'b1; g_d = gd; g_c = c; free_c = c + LAT + 3;
         g_addr  = gd ? d_addr : if_addr;
         g_we    = gd && d_we;
         g_wdata = d_wdata;
         g_rd    = ref_mem[g_addr[9:2]];
         if (g_we) ref_mem[g_addr[9:2]] = d_wdata;
         last_d  = gd;
      end
   endtask

   task automatic run(input int n);
      repeat (n) tick();
   endtask

   initial begin
      if_req = 0; if_addr = 0; d_req = 0; d_we = 0; d_addr = 0; d_wdata = 0;
      if_req1 = 0; if_addr1 = 0; d_req1 = 0; d_we1 = 0; d_addr1 = 0; d_wdata1 = 0;
      mem_rdata1 = 32'hC0DE_0000;
      raise_pct = 0;
      model_reset();
      rst = 1'b1;
      #1 rst = 1'b0;
      repeat (3) @(negedge clk);
      check("rst_busy",   32'(busy),   32'd0);
      check("rst_mem_en", 32'(mem_en), 32'd0);
      check("rst_acks",   32'({if_ack, d_ack, mem_we}), 32'd0);
      check("rst_addr",   mem_addr,  32'd0);
      check("rst_wdata",  mem_wdata, 32'd0);
      check("rst_rdata",  if_rdata | d_rdata, 32'd0);

      // Release in mid-cycle: this is cycle 0 of both DUTs.
      rst = 1'b1;
      d_req1 = 1'b1; d_we1 = 1'b0; d_addr1 = 32'h40;

      // MEM_LAT=1: ack in cycle 3 carrying the word presented in cycle 2.
      for (int k = 1; k <= 6; k++) begin
         @(negedge clk);
         c++;
         check("l1_mem_en", 32'(mem_en1), 32'(k == 1));
         check("l1_d_ack",  32'(d_ack1),  32'(k == 3));
         check("l1_if_ack", 32'(if_ack1), 32'd0);
         if (k == 1) check("l1_addr", mem_addr1, 32'h40);
         if (k == 3) check("l1_rdata", d_rdata1, 32'hC0DE_0002);
         if (k == 4) d_req1 = 1'b0;
         mem_rdata1 = 32'hC0DE_0000 + 32'(k);
      end

      // Fetch read from 0x10.
      if_ack_c = -1; d_ack_c = -1;
      want_if = 1'b1; want_if_addr = 32'h10;
      run(8);
      check("fetch_lat",   32'(if_ack_c - raise_if_c), 32'd4);
      check("fetch_rdata", if_rdata, 32'h0050_0093);
      check("fetch_no_d",  32'(d_ack_c), 32'hFFFF_FFFF);

      // Store 0xDEADBEEF to 0x100, then load it back.
      want_d = 1'b1; want_d_we = 1'b1; want_d_addr = 32'h100; want_d_wdata = 32'hDEAD_BEEF;
      run(8);
      check("store_lat", 32'(d_ack_c - raise_d_c), 32'd4);
      want_d = 1'b1; want_d_we = 1'b0; want_d_addr = 32'h100;
      run(8);
      check("load_back", d_rdata, 32'hDEAD_BEEF);

      // Simultaneous requests.
      want_if = 1'b1; want_if_addr = 32'h24;
      want_d = 1'b1; want_d_we = 1'b0; want_d_addr = 32'h2C;
      run(14);
      check("tie_if_lat", 32'(if_ack_c - raise_if_c), 32'(TIE_IF_LAT));
      check("tie_d_lat",  32'(d_ack_c - raise_d_c),   32'(TIE_D_LAT));

      // Both requesters saturated, then random mixed traffic.
      raise_pct = 100;
      run(30);
      raise_pct = 35;
      run(2000);
      raise_pct = 0;
      run(15);

      // Reset during WAIT: everything clears at once and no ack follows.
      want_d = 1'b1; want_d_we = 1'b0; want_d_addr = 32'h80;
      run(3);
      #2 rst = 1'b0;
      #1;
      check("mid_rst_busy",  32'(busy),   32'd0);
      check("mid_rst_en",    32'({mem_en, mem_we}), 32'd0);
      check("mid_rst_acks",  32'({if_ack, d_ack}),  32'd0);
      check("mid_rst_addr",  mem_addr | mem_wdata,  32'd0);
      check("mid_rst_rdata", if_rdata | d_rdata,    32'd0);
      if_req = 1'b0; d_req = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      model_reset();
      if_ack_c = -1; d_ack_c = -1;
      run(8);
      check("post_rst_no_ack", 32'(if_ack_c & d_ack_c), 32'hFFFF_FFFF);

      // First tie after reset.
      want_if = 1'b1; want_if_addr = 32'h30;
      want_d = 1'b1; want_d_we = 1'b1; want_d_addr = 32'h34; want_d_wdata = 32'h1234_5678;
      run(14);
      check("rst_tie_if_lat", 32'(if_ack_c - raise_if_c), 32'(TIE_IF_LAT));
      check("rst_tie_d_lat",  32'(d_ack_c - raise_d_c),   32'(TIE_D_LAT));
      raise_pct = 50;
      run(200);
      raise_pct = 0;
      run(15);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
